alu_arbiter: RTL and testbench
==============================

// Module: alu_arbiter
// PURPOSE
//  Shares one combinational ALU (4-bit op, 32-bit A/B -> Y, Z) between two requesters.
//  Round-robin arbitration, registered operands and result, valid/ready handshake on every channel.
//  Sits between two issuing units (e.g. address-gen and execute) and the single ALU instance.
//  Tags each response with the requester ID; drops a response that is not collected in time.
// PARAMETERS
//  DATA_W       32  operand/result width; must be 32 (fixed by ALU)
//  RSP_TIMEOUT  16  cycles rsp_valid may wait for rsp_ready before drop; 0 = wait forever
// PORTS
//  clk        in   1       single system clock, rising edge
//  reset      in   1       synchronous, active-high reset
//  r0_valid   in   1       requester 0 has an operation
//  r0_ready   out  1       requester 0 operation accepted this cycle (valid&&ready)
//  r0_op      in   4       ALU op: [3:2] 00 add/sub(op[1]), 01 logic(op[1:0]), 10 SLT, 11 -> Y=0
//  r0_a       in   DATA_W  operand A, requester 0
//  r0_b       in   DATA_W  operand B, requester 0
//  r1_valid, r1_ready, r1_op, r1_a, r1_b: same as above, requester 1
//  rsp_valid  out  1       result available
//  rsp_id     out  1       requester that owns the result (0/1)
//  rsp_y      out  DATA_W  registered ALU result
//  rsp_z      out  1       registered zero flag (rsp_y == 0)
//  rsp_ready  in   1       owner accepts result this cycle
//  rsp_drop   out  1       one-cycle pulse: result discarded on timeout
//  busy       out  1       high in every state except IDLE
// BEHAVIOUR
//  Reset: state=IDLE; r0_ready=r1_ready=0; rsp_valid=0; rsp_id=0; rsp_y=0; rsp_z=0;
//   rsp_drop=0; busy=0; last_grant=1 (so requester 0 wins first tie); timeout counter=0.
//  Reset mid-operation: any in-flight op and pending result are discarded, no rsp_drop pulse.
//  FSM IDLE -> EXEC -> DONE -> IDLE:
//   IDLE: grant = only valid requester; if both valid, grant != last_grant.
//    rX_ready asserted combinationally for the granted X only (at most one ready high).
//    On handshake: latch op/A/B, owner<=X, last_grant<=X, go EXEC. No valid: stay.
//   EXEC: ALU evaluates latched operands; Y/Z registered into rsp_y/rsp_z, rsp_id<=owner;
//    go DONE. Exactly one cycle.
//   DONE: rsp_valid=1, rsp_y/rsp_z/rsp_id stable until handshake or drop.
//    rsp_ready=1 -> rsp_valid falls next cycle, go IDLE.
//    Timeout counter increments each DONE cycle without rsp_ready; on reaching RSP_TIMEOUT
//    (when nonzero): rsp_drop pulses 1 cycle, rsp_valid falls, go IDLE.
//    rsp_ready in the same cycle as the timeout wins: normal accept, no drop.
//  Latency: accept in cycle t -> rsp_valid high from t+2. Peak throughput 1 op / 3 cycles.
//  No request is accepted outside IDLE; rX_ready=0 in EXEC/DONE regardless of rX_valid.
//  A requester may drop rX_valid before its handshake; arbiter re-evaluates each IDLE cycle.
//  Operand changes after the handshake have no effect (latched copies used).
//  op[3:2]=11: result 0, rsp_z=1; not an error.
//  SLT signed; sub is two's complement, wrap-around, no overflow flag.
//  rsp_ready while rsp_valid=0 is ignored.
//  busy = (state != IDLE).
// TESTING
//  1. r0: op=0000 A=5 B=7 -> r0_ready at t; rsp_valid at t+2: id=0, Y=12, Z=0.
//  2. r1: op=0010 A=3 B=3 -> id=1, Y=0, Z=1; r1: op=1000 A=-1 B=1 -> Y=1 (signed SLT).
//  3. r0 and r1 valid every cycle from reset, rsp_ready=1 -> grants 0,1,0,1;
//     new accept every 3 cycles.
//  4. r0 op=0100 (AND) A=F0F0_F0F0 B=FF00_FF00, rsp_ready=0 for 16 cycles ->
//     rsp_drop pulse; IDLE; next r1 request accepted.
//  5. Assert reset in DONE with rsp_valid=1 -> next cycle rsp_valid=0, busy=0, no rsp_drop;
//     first tie after reset granted to r0.
//  6. r0 op=1100, any A/B -> Y=0, Z=1; change r0_a during EXEC -> result unchanged.

Source files
------------

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between two requesters.
// Round-robin grant, registered operands and result, valid/ready on every channel.
// A response left uncollected for RSP_TIMEOUT cycles is dropped (0 = wait forever).
module alu_arbiter #(
  parameter int DATA_W      = 32,
  parameter int RSP_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              r0_valid,
  output logic              r0_ready,
  input  logic [3:0]        r0_op,
  input  logic [DATA_W-1:0] r0_a,
  input  logic [DATA_W-1:0] r0_b,
  input  logic              r1_valid,
  output logic              r1_ready,
  input  logic [3:0]        r1_op,
  input  logic [DATA_W-1:0] r1_a,
  input  logic [DATA_W-1:0] r1_b,
  output logic              rsp_valid,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_y,
  output logic              rsp_z,
  input  logic              rsp_ready,
  output logic              rsp_drop,
  output logic              busy
);

  // Counter wide enough to hold RSP_TIMEOUT; one extra bit in the compare avoids wrap.
  localparam int CNT_W = (RSP_TIMEOUT > 1) ? $clog2(RSP_TIMEOUT + 1) : 1;
  localparam logic [CNT_W:0] TIMEOUT_VAL = (CNT_W + 1)'(RSP_TIMEOUT);
  localparam logic [CNT_W:0] CNT_ONE     = (CNT_W + 1)'(1);
  localparam bit             TIMEOUT_EN  = (RSP_TIMEOUT != 0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                lastGrant_q;
  logic                owner_q;
  logic [3:0]          op_q;
  logic [DATA_W-1:0]   a_q, b_q;
  logic                rspId_q;
  logic [DATA_W-1:0]   rspY_q;
  logic                rspZ_q;
  logic [CNT_W-1:0]    cnt_q;

  logic                grantId;
  logic                accept;
  logic                timeoutHit;
  logic [DATA_W-1:0]   aluY;

  assign timeoutHit = TIMEOUT_EN && (({1'b0, cnt_q} + CNT_ONE) == TIMEOUT_VAL);

  // Shared ALU evaluated on the latched operands only.
  always_comb begin
    aluY = '0;
    case (op_q[3:2])
      2'b00: aluY = op_q[1] ? (a_q - b_q) : (a_q + b_q);
      2'b01: begin
        case (op_q[1:0])
          2'b00:   aluY = a_q & b_q;
          2'b01:   aluY = a_q | b_q;
          2'b10:   aluY = a_q ^ b_q;
          default: aluY = ~(a_q | b_q);
        endcase
      end
      2'b10:   aluY = {{(DATA_W - 1){1'b0}}, ($signed(a_q) < $signed(b_q))};
      default: aluY = '0;
    endcase
  end

  // Arbitration, handshake strobes and next-state selection.
  always_comb begin
    state_d  = state_q;
    grantId  = 1'b0;
    accept   = 1'b0;
    r0_ready = 1'b0;
    r1_ready = 1'b0;
    rsp_drop = 1'b0;
    case (state_q)
      IDLE: begin
        if (!reset) begin
          grantId  = (r0_valid && r1_valid) ? ~lastGrant_q : r1_valid;
          accept   = r0_valid || r1_valid;
          r0_ready = accept && !grantId;
          r1_ready = accept && grantId;
          if (accept) begin
            state_d = EXEC;
          end
        end
      end
      EXEC: state_d = DONE;
      DONE: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end else if (timeoutHit) begin
          rsp_drop = !reset;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, operand latch, result register and response-wait counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      lastGrant_q <= 1'b1;
      owner_q     <= 1'b0;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      rspId_q     <= 1'b0;
      rspY_q      <= '0;
      rspZ_q      <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        owner_q     <= grantId;
        lastGrant_q <= grantId;
        op_q        <= grantId ? r1_op : r0_op;
        a_q         <= grantId ? r1_a : r0_a;
        b_q         <= grantId ? r1_b : r0_b;
      end
      if (state_q == EXEC) begin
        rspY_q  <= aluY;
        rspZ_q  <= (aluY == '0);
        rspId_q <= owner_q;
      end
      if (state_q == DONE && !rsp_ready) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end else begin
        cnt_q <= '0;
      end
    end
  end

  assign rsp_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign rsp_id    = rspId_q;
  assign rsp_y     = rspY_q;
  assign rsp_z     = rspZ_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: table vectors, directed corner sequences and a randomized run,
// all compared against a transaction-level reference model kept in the bench.
module tb_alu_arbiter;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        r0_valid, r1_valid, rsp_ready;
  logic [3:0]  r0_op, r1_op;
  logic [31:0] r0_a, r0_b, r1_a, r1_b;
  logic        r0_ready, r1_ready, rsp_valid, rsp_id, rsp_z, rsp_drop, busy;
  logic [31:0] rsp_y;

  always #5 clk = ~clk;

  alu_arbiter #(.DATA_W(32), .RSP_TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_op(r0_op), .r0_a(r0_a), .r0_b(r0_b),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_op(r1_op), .r1_a(r1_a), .r1_b(r1_b),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_y(rsp_y), .rsp_z(rsp_z),
    .rsp_ready(rsp_ready), .rsp_drop(rsp_drop), .busy(busy)
  );

  typedef struct {
    bit          id;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] y;
    logic        z;
  } vec_t;

  vec_t vecs[10];

  int checksTotal  = 0;
  int checksPassed = 0;
  int cyc          = 0;

  // Reference model: one outstanding transaction described by its accept cycle.
  bit          mInFlight  = 1'b0;
  int          mAcceptCyc = 0;
  bit          mLastGrant = 1'b1;
  bit          mId        = 1'b0;
  logic [31:0] mY         = '0;

  // Handshakes observed on the DUT ports.
  int obsCycQ[$];
  bit obsIdQ[$];

  function automatic logic [31:0] refAlu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    sa = a;
    sb = b;
    case (op[3:2])
      2'b00:   return op[1] ? a - b : a + b;
      2'b01:   begin
        if (op[1:0] == 2'b00) return a & b;
        if (op[1:0] == 2'b01) return a | b;
        if (op[1:0] == 2'b10) return a ^ b;
        return ~(a | b);
      end
      2'b10:   return (sa < sb) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checksTotal++;
    if (act === exp) checksPassed++;
    else $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Compare the current cycle against the model, then advance the model.
  task automatic checkOutput();
    bit expR0, expR1, expBusy, expValid, expDrop, g, hs;
    int k;
    expR0 = 0; expR1 = 0; expBusy = 0; expValid = 0; expDrop = 0; g = 0; hs = 0;
    if (reset) begin
      mInFlight  = 1'b0;
      mLastGrant = 1'b1;
    end else begin
      if (!mInFlight) begin
        hs = r0_valid || r1_valid;
        g  = (r0_valid && r1_valid) ? !mLastGrant : r1_valid;
        expR0 = hs && !g;
        expR1 = hs && g;
      end else if (cyc == mAcceptCyc + 1) begin
        expBusy = 1;
      end else begin
        expBusy  = 1;
        expValid = 1;
        k = cyc - (mAcceptCyc + 2);
        expDrop = !rsp_ready && (TO != 0) && (k + 1 == TO);
        chk("rspId", rsp_id, mId);
        chk("rspY", rsp_y, mY);
        chk("rspZ", rsp_z, (mY == 32'd0));
        if (rsp_ready || expDrop) mInFlight = 1'b0;
      end
      chk("r0Ready", r0_ready, expR0);
      chk("r1Ready", r1_ready, expR1);
      chk("busy", busy, expBusy);
      chk("rspValid", rsp_valid, expValid);
      chk("rspDrop", rsp_drop, expDrop);
      if (hs) begin
        mInFlight  = 1'b1;
        mAcceptCyc = cyc;
        mId        = g;
        mLastGrant = g;
        mY = g ? refAlu(r1_op, r1_a, r1_b) : refAlu(r0_op, r0_a, r0_b);
      end
      if (r0_valid && r0_ready) begin obsCycQ.push_back(cyc); obsIdQ.push_back(1'b0); end
      if (r1_valid && r1_ready) begin obsCycQ.push_back(cyc); obsIdQ.push_back(1'b1); end
    end
  endtask

  // Drive one cycle of inputs after the falling edge, then check before the rising edge.
  task automatic applyStimulus(input bit v0, input logic [3:0] op0, input logic [31:0] a0, input logic [31:0] b0,
                               input bit v1, input logic [3:0] op1, input logic [31:0] a1, input logic [31:0] b1,
                               input bit rdy, input bit rst);
    @(negedge clk);
    cyc++;
    reset = rst; rsp_ready = rdy;
    r0_valid = v0; r0_op = op0; r0_a = a0; r0_b = b0;
    r1_valid = v1; r1_op = op1; r1_a = a1; r1_b = b1;
    #1;
    checkOutput();
  endtask

  initial begin
    int n, validCnt;
    bit dropSeen, v0, v1, rdy, rst;
    logic [31:0] ra, rb;

    reset = 1'b1; rsp_ready = 0;
    r0_valid = 0; r0_op = 0; r0_a = 0; r0_b = 0;
    r1_valid = 0; r1_op = 0; r1_a = 0; r1_b = 0;

    vecs[0] = '{1'b0, 4'b0000, 32'd5,         32'd7,         32'd12,        1'b0};
    vecs[1] = '{1'b1, 4'b0010, 32'd3,         32'd3,         32'd0,         1'b1};
    vecs[2] = '{1'b1, 4'b1000, 32'hFFFF_FFFF, 32'd1,         32'd1,         1'b0};
    vecs[3] = '{1'b0, 4'b0100, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0};
    vecs[4] = '{1'b0, 4'b0101, 32'h0F0F_0000, 32'h0000_0F0F, 32'h0F0F_0F0F, 1'b0};
    vecs[5] = '{1'b1, 4'b0110, 32'hAAAA_5555, 32'hAAAA_5555, 32'd0,         1'b1};
    vecs[6] = '{1'b0, 4'b1100, 32'h1234,      32'h5678,      32'd0,         1'b1};
    vecs[7] = '{1'b1, 4'b0010, 32'd0,         32'd1,         32'hFFFF_FFFF, 1'b0};
    vecs[8] = '{1'b0, 4'b1000, 32'd1,         32'hFFFF_FFFF, 32'd0,         1'b1};
    vecs[9] = '{1'b1, 4'b0111, 32'd0,         32'd0,         32'hFFFF_FFFF, 1'b0};

    // Reset state
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("resetRspId", rsp_id, 0);
    chk("resetRspY", rsp_y, 0);
    chk("resetRspZ", rsp_z, 0);
    chk("resetBusy", busy, 0);
    chk("resetValid", rsp_valid, 0);

    // Table vectors: accept at t, operands scrambled in EXEC, result checked at t+2
    for (int i = 0; i < 10; i++) begin
      if (vecs[i].id == 1'b0)
        applyStimulus(1, vecs[i].op, vecs[i].a, vecs[i].b, 0, 0, 0, 0, 1, 0);
      else
        applyStimulus(0, 0, 0, 0, 1, vecs[i].op, vecs[i].a, vecs[i].b, 1, 0);
      chk("vecReady", vecs[i].id ? r1_ready : r0_ready, 1);
      applyStimulus(0, 4'hF, ~vecs[i].a, ~vecs[i].b, 0, 4'hF, ~vecs[i].a, ~vecs[i].b, 1, 0);
      chk("vecExecValid", rsp_valid, 0);
      applyStimulus(0, 4'hF, ~vecs[i].a, ~vecs[i].b, 0, 4'hF, ~vecs[i].a, ~vecs[i].b, 1, 0);
      chk("vecRspValid", rsp_valid, 1);
      chk("vecRspId", rsp_id, vecs[i].id);
      chk("vecRspY", rsp_y, vecs[i].y);
      chk("vecRspZ", rsp_z, vecs[i].z);
    end

    // Both requesters always valid from reset: alternate grants every 3 cycles
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    n = obsCycQ.size();
    for (int i = 0; i < 12; i++)
      applyStimulus(1, 4'b0000, 32'(i), 32'd1, 1, 4'b0101, 32'(i), 32'd16, 1, 0);
    chk("rrCount", obsCycQ.size() - n, 4);
    for (int j = 0; j < 4; j++)
      if (n + j < obsCycQ.size()) chk("rrGrant", obsIdQ[n + j], j % 2);
    for (int j = 1; j < 4; j++)
      if (n + j < obsCycQ.size()) chk("rrSpacing", obsCycQ[n + j] - obsCycQ[n + j - 1], 3);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);

    // Uncollected response times out; waiting r1 is served right after the drop
    applyStimulus(1, 4'b0100, 32'hF0F0_F0F0, 32'hFF00_FF00, 0, 0, 0, 0, 0, 0);
    chk("toAccept", r0_ready, 1);
    validCnt = 0; dropSeen = 0;
    for (int k = 0; k < 40 && !dropSeen; k++) begin
      applyStimulus(0, 0, 0, 0, 1, 4'b0000, 32'd100, 32'd23, 0, 0);
      if (rsp_valid) validCnt++;
      if (rsp_drop) dropSeen = 1;
    end
    chk("toDropSeen", dropSeen, 1);
    chk("toValidCycles", validCnt, TO);
    applyStimulus(0, 0, 0, 0, 1, 4'b0000, 32'd100, 32'd23, 0, 0);
    chk("toNextR1Ready", r1_ready, 1);
    chk("toNextDrop", rsp_drop, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    chk("toNextY", rsp_y, 123);
    chk("toNextId", rsp_id, 1);

    // Reset while a result waits in DONE; first tie afterwards goes to r0
    applyStimulus(1, 4'b0000, 32'd1, 32'd2, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("preResetValid", rsp_valid, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    applyStimulus(1, 4'b0000, 32'd9, 32'd9, 1, 4'b0000, 32'd7, 32'd7, 0, 0);
    chk("postResetValid", rsp_valid, 0);
    chk("postResetBusy", busy, 0);
    chk("postResetDrop", rsp_drop, 0);
    chk("postResetY", rsp_y, 0);
    chk("postResetTieR0", r0_ready, 1);
    chk("postResetTieR1", r1_ready, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    chk("postResetY2", rsp_y, 18);

    // Randomized traffic with periodic long stalls and rare resets
    for (int i = 0; i < 600; i++) begin
      v0  = ($urandom % 2) == 0;
      v1  = ($urandom % 2) == 0;
      rdy = (((i / 50) % 4) == 3) ? 1'b0 : (($urandom % 3) != 0);
      rst = ($urandom % 150) == 0;
      ra  = $urandom;
      rb  = (($urandom % 4) == 0) ? ra : $urandom;
      applyStimulus(v0, 4'($urandom), ra, rb, v1, 4'($urandom), rb, ra, rdy, rst);
    end

    $display("%0d/%0d checks passed", checksPassed, checksTotal);
    $finish;
  end

endmodule
